// File: rtl/eda_window_fetch_if.sv
// eda_window_fetch_if: request, RAM read and window result signals of the window fetch stage.
interface eda_window_fetch_if #(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = $clog2(M*N),
    parameter int I_WIDTH      = $clog2(M),
    parameter int J_WIDTH      = $clog2(N)
);
    logic                                start;
    logic [I_WIDTH-1:0]                  centre_i;
    logic [J_WIDTH-1:0]                  centre_j;
    logic                                busy;
    logic                                mem_rd_en;
    logic [ADDR_WIDTH-1:0]               mem_rd_addr;
    logic [PIXEL_WIDTH-1:0]              mem_rd_data;
    logic                                new_pixel;
    logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values;
    logic [WINDOW_WIDTH-2:0]             neigh_addr_valid;
    logic [ADDR_WIDTH-1:0]               centre_addr;

    modport master (
        output start, centre_i, centre_j, mem_rd_data,
        input  busy, mem_rd_en, mem_rd_addr, new_pixel, window_values, neigh_addr_valid, centre_addr
    );
    modport slave (
        input  start, centre_i, centre_j, mem_rd_data,
        output busy, mem_rd_en, mem_rd_addr, new_pixel, window_values, neigh_addr_valid, centre_addr
    );
endinterface

// File: rtl/eda_window_fetch.sv
// eda_window_fetch: reads the 3x3 neighbourhood of a centre pixel from a 1-cycle-latency RAM
// and publishes the whole window atomically with a one-cycle new_pixel pulse.
module eda_window_fetch #(
    parameter int M            = 16,
    parameter int N            = 16,
    parameter int PIXEL_WIDTH  = 8,
    parameter int WINDOW_WIDTH = 9,
    parameter int ADDR_WIDTH   = $clog2(M*N),
    parameter int I_WIDTH      = $clog2(M),
    parameter int J_WIDTH      = $clog2(N)
) (
    input logic               clk,
    input logic               reset_n,
    eda_window_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;

    state_t                              state, state_nx;
    logic [I_WIDTH-1:0]                  ci;
    logic [J_WIDTH-1:0]                  cj;
    logic [1:0]                          kr, kc;
    logic [3:0]                          k;
    logic [WINDOW_WIDTH-1:0]             slot_ok, slot_ok_nx;
    logic [2:0]                          row_ok, col_ok;
    logic                                accept;
    logic                                pend, pend_ok;
    logic [3:0]                          pend_k;
    logic [PIXEL_WIDTH-1:0]              shadow    [WINDOW_WIDTH];
    logic [PIXEL_WIDTH-1:0]              shadow_nx [WINDOW_WIDTH];
    logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] win_nx, window_q;
    logic [ADDR_WIDTH-1:0]               addr_q, addr_calc, centre_q;
    logic [WINDOW_WIDTH-2:0]             neigh_q;
    logic                                new_pixel_q;

    assign k      = 4'(kr) * 4'd3 + 4'(kc);
    assign accept = state == IDLE && bus.start && 32'(bus.centre_i) < M && 32'(bus.centre_j) < N;

    always_comb begin
        row_ok = {32'(bus.centre_i) != M - 1, 1'b1, bus.centre_i != '0};
        col_ok = {32'(bus.centre_j) != N - 1, 1'b1, bus.centre_j != '0};
        slot_ok_nx = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                slot_ok_nx[r*3+c] = row_ok[r] & col_ok[c];
    end

    // Only evaluated for in-image slots, so the -1 offsets never underflow.
    assign addr_calc = (ADDR_WIDTH'(ci) + ADDR_WIDTH'(kr) - ADDR_WIDTH'(1)) * ADDR_WIDTH'(N)
                     + ADDR_WIDTH'(cj) + ADDR_WIDTH'(kc) - ADDR_WIDTH'(1);

    always_comb begin
        shadow_nx = shadow;
        if (pend) shadow_nx[pend_k] = pend_ok ? bus.mem_rd_data : '0;
        win_nx = '0;
        for (int w = 0; w < WINDOW_WIDTH; w++)
            win_nx[w*PIXEL_WIDTH +: PIXEL_WIDTH] = shadow_nx[w];
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? FETCH : IDLE;
            FETCH:   state_nx = k == 4'd8 ? LAST : FETCH;
            LAST:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ci          <= '0;
            cj          <= '0;
            kr          <= '0;
            kc          <= '0;
            slot_ok     <= '0;
            addr_q      <= '0;
            pend        <= 1'b0;
            pend_ok     <= 1'b0;
            pend_k      <= '0;
            for (int w = 0; w < WINDOW_WIDTH; w++) shadow[w] <= '0;
            window_q    <= '0;
            neigh_q     <= '0;
            centre_q    <= '0;
            new_pixel_q <= 1'b0;
        end else begin
            if (accept) begin
                ci      <= bus.centre_i;
                cj      <= bus.centre_j;
                slot_ok <= slot_ok_nx;
                kr      <= '0;
                kc      <= '0;
            end
            if (state == FETCH) begin
                kc <= kc == 2'd2 ? 2'd0 : kc + 2'd1;
                kr <= kc == 2'd2 ? kr + 2'd1 : kr;
                if (slot_ok[k]) addr_q <= addr_calc;
            end
            pend        <= state == FETCH;
            pend_k      <= k;
            pend_ok     <= slot_ok[k];
            shadow      <= shadow_nx;
            new_pixel_q <= state == LAST;
            // The last read lands during LAST, so publish the merged view rather than the stale shadow.
            if (state == LAST) begin
                window_q <= win_nx;
                neigh_q  <= {slot_ok[8:5], slot_ok[3:0]};
                centre_q <= ADDR_WIDTH'(ci) * ADDR_WIDTH'(N) + ADDR_WIDTH'(cj);
            end
        end
    end

    assign bus.busy             = state != IDLE;
    assign bus.mem_rd_en        = state == FETCH && slot_ok[k];
    assign bus.mem_rd_addr      = bus.mem_rd_en ? addr_calc : addr_q;
    assign bus.new_pixel        = new_pixel_q;
    assign bus.window_values    = window_q;
    assign bus.neigh_addr_valid = neigh_q;
    assign bus.centre_addr      = centre_q;
endmodule

// File: tb/tb_eda_window_fetch.sv
// tb_eda_window_fetch: table-driven and randomized checks of eda_window_fetch against a
// neighbourhood model computed directly from image coordinates.
module tb_eda_window_fetch;
    localparam int M = 16, N = 16, PW = 8, WW = 9, AW = 8, IW = 4, JW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    eda_window_fetch_if #(.M(M), .N(N), .PIXEL_WIDTH(PW), .WINDOW_WIDTH(WW),
                          .ADDR_WIDTH(AW), .I_WIDTH(IW), .J_WIDTH(JW)) bus ();

    eda_window_fetch #(.M(M), .N(N), .PIXEL_WIDTH(PW), .WINDOW_WIDTH(WW),
                       .ADDR_WIDTH(AW), .I_WIDTH(IW), .J_WIDTH(JW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    logic [PW-1:0] ram [M*N];
    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? ram[bus.mem_rd_addr] : PW'($urandom);

    int checks = 0, fails = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [PW*WW-1:0] exp_win;
    logic [WW-2:0]    exp_nv;
    int               exp_addr[$], exp_cyc[$];

    task automatic model(input int i, input int j);
        exp_addr.delete();
        exp_cyc.delete();
        exp_win = '0;
        exp_nv  = '0;
        for (int di = -1; di <= 1; di++)
            for (int dj = -1; dj <= 1; dj++) begin
                int  w;
                bit  ok;
                w  = (di + 1) * 3 + dj + 1;
                ok = i + di >= 0 && i + di < M && j + dj >= 0 && j + dj < N;
                if (ok) begin
                    exp_win[w*PW +: PW] = ram[(i + di) * N + j + dj];
                    exp_addr.push_back((i + di) * N + j + dj);
                    exp_cyc.push_back(1 + w);
                end
                if (w != 4) exp_nv[w < 4 ? w : w - 1] = ok;
            end
    endtask

    // nv_tab < 0 means take the neighbour mask from the model.
    task automatic run_fetch(input int i, input int j, input int nv_tab, input int ign1, input int ign2);
        int   got_addr[$], got_cyc[$];
        int   npix, npix_cyc;
        logic b1, b11, b12;
        npix = 0; npix_cyc = -1; b1 = 0; b11 = 0; b12 = 1;
        model(i, j);
        @(negedge clk);
        bus.start = 1'b1; bus.centre_i = IW'(i); bus.centre_j = JW'(j);
        @(posedge clk); #1; bus.start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.mem_rd_en) begin
                got_addr.push_back(int'(bus.mem_rd_addr));
                got_cyc.push_back(c);
            end
            if (bus.new_pixel) begin npix++; npix_cyc = c; end
            if (c == 1)  b1  = bus.busy;
            if (c == 11) b11 = bus.busy;
            if (c == 12) b12 = bus.busy;
            if (c == ign1 || c == ign2) begin
                bus.start = 1'b1; bus.centre_i = '0; bus.centre_j = '0;
            end
            @(posedge clk); #1; bus.start = 1'b0;
        end
        chk($sformatf("npix_count(%0d,%0d)", i, j), 80'(npix), 80'(1));
        chk($sformatf("npix_cycle(%0d,%0d)", i, j), 80'(npix_cyc), 80'(11));
        chk($sformatf("busy_c1_c11_c12(%0d,%0d)", i, j), {b1, b11, b12}, 80'(3'b110));
        chk($sformatf("nreads(%0d,%0d)", i, j), 80'(got_addr.size()), 80'(exp_addr.size()));
        for (int n = 0; n < got_addr.size() && n < exp_addr.size(); n++)
            chk($sformatf("read%0d(%0d,%0d) {cycle,addr}", n, i, j),
                {32'(got_cyc[n]), 32'(got_addr[n])}, {32'(exp_cyc[n]), 32'(exp_addr[n])});
        chk($sformatf("window(%0d,%0d)", i, j), 80'(bus.window_values), 80'(exp_win));
        chk($sformatf("neigh(%0d,%0d)", i, j), 80'(bus.neigh_addr_valid),
            nv_tab < 0 ? 80'(exp_nv) : 80'(nv_tab));
        chk($sformatf("centre_addr(%0d,%0d)", i, j), 80'(bus.centre_addr), 80'(i * N + j));
    endtask

    typedef struct {
        int            i;
        int            j;
        logic [WW-2:0] nv;
    } vec_t;
    vec_t tab[6];

    initial begin
        tab[0] = '{5, 5, 8'hFF};
        tab[1] = '{0, 0, 8'hD0};
        tab[2] = '{15, 15, 8'h0B};
        tab[3] = '{0, 7, 8'hF8};
        tab[4] = '{15, 0, 8'h16};
        tab[5] = '{8, 0, 8'hD6};
        for (int a = 0; a < M * N; a++) ram[a] = PW'(a);
        bus.start = 1'b0; bus.centre_i = '0; bus.centre_j = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {bus.busy, bus.mem_rd_en, bus.new_pixel, bus.neigh_addr_valid,
                           bus.centre_addr, bus.mem_rd_addr}, '0);
        chk("reset_window", 80'(bus.window_values), '0);
        @(negedge clk); reset_n = 1'b1;

        for (int t = 0; t < 6; t++) run_fetch(tab[t].i, tab[t].j, int'(tab[t].nv), -1, -1);

        // Starts while busy must be dropped without queuing.
        run_fetch(5, 5, 8'hFF, 3, 11);

        // Abort mid-fetch with an asynchronous reset.
        @(negedge clk);
        bus.start = 1'b1; bus.centre_i = 4'd5; bus.centre_j = 4'd5;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1; reset_n = 1'b0; #1;
        chk("abort_outs", {bus.busy, bus.mem_rd_en, bus.new_pixel, bus.neigh_addr_valid,
                           bus.centre_addr, bus.mem_rd_addr}, '0);
        chk("abort_window", 80'(bus.window_values), '0);
        @(negedge clk); reset_n = 1'b1;
        begin
            int np, bz;
            np = 0; bz = 0;
            for (int c = 0; c < 15; c++) begin
                @(posedge clk); #1;
                np += int'(bus.new_pixel);
                bz += int'(bus.busy);
            end
            chk("abort_no_new_pixel", 80'(np), '0);
            chk("abort_idle", 80'(bz), '0);
        end
        run_fetch(5, 5, 8'hFF, -1, -1);

        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < M * N; a++) ram[a] = PW'($urandom);
            run_fetch(int'($urandom_range(0, M - 1)), int'($urandom_range(0, N - 1)), -1,
                      int'($urandom_range(1, 11)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/eda_window_fetch.md
Name: eda_window_fetch

Overview:
- Upstream stage of eda_compare in the regional-maximum engine.
- Given a centre pixel coordinate, reads the 3x3 neighbourhood from the single-port image RAM (1-cycle read latency).
- Packs the nine pixels into window_values, derives neigh_addr_valid from image boundaries, and pulses new_pixel so eda_compare latches a coherent window.

Parameters:
- M, 16, image rows.
- N, 16, image columns.
- PIXEL_WIDTH, 8, bits per pixel.
- WINDOW_WIDTH, 9, window slots; fixed 3x3, only 9 supported.
- ADDR_WIDTH, $clog2(M*N), RAM address width.
- I_WIDTH, $clog2(M), row index width.
- J_WIDTH, $clog2(N), column index width.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request window fetch for centre_i/centre_j; accepted only when busy=0.
- centre_i  input  I_WIDTH  centre row; sampled with accepted start.
- centre_j  input  J_WIDTH  centre column; sampled with accepted start.
- busy  output  1  fetch in progress.
- mem_rd_en  output  1  RAM read strobe.
- mem_rd_addr  output  ADDR_WIDTH  RAM read address, row-major (i*N+j).
- mem_rd_data  input  PIXEL_WIDTH  RAM data, valid the cycle after mem_rd_en.
- new_pixel  output  1  one-cycle pulse: window outputs updated.
- window_values  output  PIXEL_WIDTH*WINDOW_WIDTH  packed window.
- neigh_addr_valid  output  WINDOW_WIDTH-1  in-image flag per neighbour.
- centre_addr  output  ADDR_WIDTH  centre address of the current window.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset: busy=0, mem_rd_en=0, mem_rd_addr=0, new_pixel=0, window_values=0, neigh_addr_valid=0, centre_addr=0; FSM to IDLE.
- Slot w = (di+1)*3 + (dj+1), with di,dj in {-1,0,+1}; slot 4 is the centre.
  - Slot w occupies window_values[w*PIXEL_WIDTH +: PIXEL_WIDTH].
  - Neighbour bit k maps to slot k for k<4 and to slot k+1 for k>=4.
- Slot validity: 0 <= i+di < M and 0 <= j+dj < N. Centre is always valid.
- FSM states:
  - IDLE: start=1 and centre in range -> latch i, j, compute validity, k=0, go to FETCH.
  - FETCH: 9 cycles, slot k per cycle, k=0..8.
    - Valid slot: mem_rd_en=1, mem_rd_addr=(i+di)*N+(j+dj).
    - Invalid slot: mem_rd_en=0, address held.
    - After k=8, go to LAST.
  - LAST: capture the final read, go to DONE.
  - DONE: new_pixel=1; window_values, neigh_addr_valid and centre_addr update from shadow registers on the same edge; go to IDLE.
- Read capture:
  - Data for a slot issued in cycle c is registered into the shadow window at the end of cycle c+1.
  - Invalid slots load 0.
- Timing: start accepted in cycle 0 -> busy=1 in cycles 1..11 -> reads issued in cycles 1..9 -> new_pixel=1 in cycle 11 -> busy=0 in cycle 12.
- Fixed latency of 11 cycles, independent of boundary position.
- window_values, neigh_addr_valid and centre_addr are stable between new_pixel pulses; they never show a partial window.
- start while busy=1: ignored, no queuing.
- start with centre_i>=M or centre_j>=N: ignored, busy stays 0.
- Address arithmetic is computed at ADDR_WIDTH and never wraps, because only valid slots are addressed.
- Reset asserted mid-fetch: immediate return to reset values; no new_pixel is generated for the aborted fetch.

Test Plan:
- Interior centre (5,5), M=N=16, RAM[a]=a[7:0] -> reads 68,69,70,84,85,86,100,101,102 in cycles 1..9; new_pixel in cycle 11; neigh_addr_valid=8'hFF; centre_addr=85; slot4=85.
- Corner (0,0) -> mem_rd_en only for addresses 0,1,16,17; neigh_addr_valid=8'hD0; slots 0,1,2,3,6=0; new_pixel still in cycle 11.
- Corner (15,15) -> reads 238,239,254,255; neigh_addr_valid=8'h0B; slots 2,5,6,7,8=0.
- Edge (0,7) -> neigh_addr_valid=8'hF8; reads 6,7,8,22,23,24.
- start pulsed in cycles 3 and 11 after an accepted start in cycle 0 -> both ignored; exactly one new_pixel; outputs unchanged until a start with busy=0.
- reset_n low in cycle 5 of a fetch -> all outputs 0 immediately; no new_pixel; a fresh start at (5,5) after release produces the correct window.
